// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: code width, sequencer FSM states and
// one-hot/encode helpers for the default 8-request configuration.
package alu_pkg;

    localparam int ALU_W = 3;
    localparam int ALU_N = 1 << ALU_W;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    function automatic logic [ALU_N-1:0] onehot(input logic [ALU_W-1:0] idx);
        return ALU_N'(1) << idx;
    endfunction

    // Highest set index of vec; returns 0 for an empty vector.
    function automatic logic [ALU_W-1:0] encode(input logic [ALU_N-1:0] vec);
        logic [ALU_W-1:0] r;
        r = '0;
        for (int i = 0; i < ALU_N; i++) begin
            if (vec[i]) r = ALU_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc8to3.sv
// Combinational priority encoder: idx is the highest set bit of vec,
// any flags a non-empty vector.
module prio_enc8to3 #(
    parameter int W = 3
) (
    input  logic [(1<<W)-1:0] vec,
    output logic [W-1:0]      idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < (1 << W); i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder8to3.sv
// Sticky request latch + priority encoder issuing the selected index over
// valid/ready. Define ROUND_ROBIN_EN for rotating instead of fixed priority.
module request_encoder8to3
    import alu_pkg::*;
#(
    parameter int           W        = ALU_W,
    parameter logic [W-1:0] RST_CODE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                En,
    input  logic [(1<<W)-1:0]   req,
    output logic [W-1:0]        code,
    output logic                valid,
    input  logic                ready,
    output logic [(1<<W)-1:0]   pending
);

    localparam int N = 1 << W;

    state_e         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   pending_q, pending_d;

    logic           accept;
    logic [N-1:0]   clr;
    logic [N-1:0]   cand;
    logic [N-1:0]   enc_vec;
    logic [W-1:0]   enc_idx;
    logic [W-1:0]   sel;
    logic           any;

    always_comb begin
        accept    = valid_q && ready;
        clr       = accept ? (N'(1) << code_q) : '0;
        // A request re-asserted in its own accept cycle survives the clear.
        cand      = (pending_q & ~clr) | req;
        pending_d = cand;
    end

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Rotate so the search start lands on the encoder's top bit; the encoder
    // returns j for offset N-1-j, which is ~j in W bits.
    always_comb begin
        ptr_d   = accept ? (code_q + W'(1)) : ptr_q;
        enc_vec = '0;
        for (int k = 0; k < N; k++) begin
            enc_vec[N-1-k] = cand[ptr_d + W'(k)];
        end
        sel = ptr_d + ~enc_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        enc_vec = cand;
        sel     = enc_idx;
    end
`endif

    prio_enc8to3 #(.W(W)) u_enc (
        .vec (enc_vec),
        .idx (enc_idx),
        .any (any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (En && any) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Presented code is frozen until accepted; no preemption.
                if (accept) begin
                    if (En && any) begin
                        code_d = sel;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= RST_CODE;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_request_encoder8to3.sv
// Randomized + directed bench for request_encoder8to3; expected outputs are
// queued by the driver from a request-set model and checked by a monitor.
module tb_request_encoder8to3;

    localparam int W = 3;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         En = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] req = '0;
    logic [W-1:0] code;
    logic         valid;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    request_encoder8to3 #(.W(W), .RST_CODE(3'd0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .En      (En),
        .req     (req),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] c;
        logic [N-1:0] p;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 0;

    // Reference model: a set of outstanding request numbers and the one
    // currently offered to the consumer.
    bit m_set[N];
    bit m_v;
    int m_c;
    int m_ptr;

    function automatic logic [N-1:0] set_vec();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (m_set[i]) r[i] = 1'b1;
        return r;
    endfunction

    task automatic cyc(input bit r, input bit en, input logic [N-1:0] rq,
                       input bit rdy, input string tag);
        exp_t e;
        bit   acc;
        bit   found;
        int   pick;
        int   start;
        @(negedge clk);
        rst_n = r; En = en; req = rq; ready = rdy;
        if (!r) begin
            foreach (m_set[i]) m_set[i] = 0;
            m_v = 0; m_c = 0; m_ptr = 0;
        end else begin
            acc = m_v && rdy;
            if (acc) begin
                m_set[m_c] = 0;
                m_ptr = (m_c + 1) % N;
            end
            for (int i = 0; i < N; i++) if (rq[i]) m_set[i] = 1;
            found = 0; pick = 0;
`ifdef ROUND_ROBIN_EN
            start = m_ptr;
            for (int k = 0; k < N; k++) begin
                if (!found && m_set[(start + k) % N]) begin
                    found = 1; pick = (start + k) % N;
                end
            end
`else
            start = N - 1;
            for (int i = start; i >= 0; i--) begin
                if (!found && m_set[i]) begin
                    found = 1; pick = i;
                end
            end
`endif
            if (!m_v || acc) begin
                if (en && found) begin
                    m_v = 1; m_c = pick;
                end else begin
                    m_v = 0;
                end
            end
        end
        e.v = m_v; e.c = m_c[W-1:0]; e.p = set_vec(); e.tag = tag;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, want);
    endtask

    // Monitor: one queued expectation per clock edge, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".valid"}, N'(valid), N'(e.v));
                if (e.v || e.tag == "rst") chk({e.tag, ".code"}, N'(code), N'(e.c));
                chk({e.tag, ".pending"}, pending, e.p);
            end
        end
    end

    initial begin
        int t;
        // Reset with all requests asserted, then release.
        cyc(0, 1, 8'hFF, 0, "rst");
        cyc(0, 1, 8'hFF, 0, "rst");
        cyc(1, 1, 8'hFF, 0, "rst_rel");
        repeat (10) cyc(1, 1, 8'h00, 1, "drain_ff");
        // Single request held un-accepted, then accepted.
        cyc(1, 1, 8'h04, 0, "single");
        cyc(1, 1, 8'h00, 0, "single_hold");
        cyc(1, 1, 8'h00, 1, "single_acc");
        cyc(1, 1, 8'h00, 1, "single_idle");
        // Back-to-back issue of a pulsed pattern.
        cyc(1, 1, 8'hA5, 1, "b2b");
        repeat (5) cyc(1, 1, 8'h00, 1, "b2b_run");
        // No preemption of a presented code.
        cyc(1, 1, 8'h02, 0, "hold1");
        cyc(1, 1, 8'h40, 0, "nopreempt");
        cyc(1, 1, 8'h00, 0, "nopreempt2");
        cyc(1, 1, 8'h00, 1, "acc1");
        cyc(1, 1, 8'h00, 1, "acc6");
        cyc(1, 1, 8'h00, 1, "idle");
        // Set wins over the clear in the accept cycle.
        cyc(1, 1, 8'h08, 0, "sw_issue");
        cyc(1, 1, 8'h08, 1, "setwins");
        cyc(1, 1, 8'h08, 1, "setwins2");
        repeat (3) cyc(1, 1, 8'h00, 1, "sw_drain");
        // All requests held: fixed vs rotating order, then issue disabled.
        repeat (10) cyc(1, 1, 8'hFF, 1, "all_held");
        repeat (3) cyc(1, 0, 8'hFF, 1, "en_off");
        repeat (3) cyc(1, 0, 8'h00, 1, "en_off_idle");
        repeat (10) cyc(1, 1, 8'h00, 1, "en_on_drain");
        // Reset in the middle of a handshake.
        cyc(1, 1, 8'h10, 0, "pre_rst");
        cyc(0, 1, 8'h00, 1, "rst");
        cyc(1, 1, 8'h00, 1, "post_rst");
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            t = int'($urandom_range(0, 3));
            cyc(1, ($urandom_range(0, 7) != 0), (t == 0) ? 8'($urandom) : 8'h00,
                ($urandom_range(0, 2) != 0), "rand");
        end
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        done = 1;
        $finish;
    end

endmodule
